// File: rtl/alu_exec_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_exec_stage                                                   |
// | Desc    : ALU execute stage with valid/ready handshake and held result.   |
// |           Define ALU_EXEC_MUL_EN to add an iterative shift-add MUL.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module alu_exec_stage #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUop,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [3:0]      operation
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_HOLD = 2'd2;

  localparam logic [3:0] c_OP_AND  = 4'b0000;
  localparam logic [3:0] c_OP_OR   = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b0010;
  localparam logic [3:0] c_OP_SLT  = 4'b0011;
  localparam logic [3:0] c_OP_SLTU = 4'b0100;
  localparam logic [3:0] c_OP_SUB  = 4'b0110;
  localparam logic [3:0] c_OP_SLL  = 4'b0111;
  localparam logic [3:0] c_OP_SRL  = 4'b1000;
  localparam logic [3:0] c_OP_SRA  = 4'b1001;
  localparam logic [3:0] c_OP_XOR  = 4'b1010;

  localparam logic [6:0] c_F7_BASE = 7'b0000000;
  localparam logic [6:0] c_F7_ALT  = 7'b0100000;

`ifdef ALU_EXEC_MUL_EN
  localparam logic [1:0]     c_ST_MUL  = 2'd1;
  localparam logic [3:0]     c_OP_MUL  = 4'b1100;
  localparam logic [6:0]     c_F7_MUL  = 7'b0000001;
  localparam logic [SHW-1:0] c_CNT_LAST = SHW'(XLEN - 1);
`endif

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_illegal;
  logic [3:0]      r_operation;

  logic [3:0]      w_op;
  logic            w_illegal;
  logic            w_rtype;
  logic            w_f7_base;
  logic            w_f7_alt;
  logic            w_accept;
  logic [XLEN-1:0] w_res;
  logic [SHW-1:0]  w_shamt;

`ifdef ALU_EXEC_MUL_EN
  logic            w_is_mul;
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

  assign w_rtype   = (ALUop == 2'b10);
  assign w_f7_base = (funct7 == c_F7_BASE);
  assign w_f7_alt  = (funct7 == c_F7_ALT);
  assign w_shamt   = op_b[SHW-1:0];

  // I-type non-shift ops carry immediate bits in funct7, so only R-type and shifts check it.
  always_comb begin
    w_op      = c_OP_ADD;
    w_illegal = 1'b0;
`ifdef ALU_EXEC_MUL_EN
    w_is_mul  = 1'b0;
`endif
    case (ALUop)
      2'b00: w_op = c_OP_ADD;
      2'b01: w_op = c_OP_SUB;
      default: begin
        case (funct3)
          3'b000: begin
            if (w_rtype && w_f7_alt) begin
              w_op = c_OP_SUB;
`ifdef ALU_EXEC_MUL_EN
            end else if (w_rtype && (funct7 == c_F7_MUL)) begin
              w_op     = c_OP_MUL;
              w_is_mul = 1'b1;
`endif
            end else begin
              w_op      = c_OP_ADD;
              w_illegal = w_rtype && !w_f7_base;
            end
          end
          3'b111: begin w_op = c_OP_AND;  w_illegal = w_rtype && !w_f7_base; end
          3'b110: begin w_op = c_OP_OR;   w_illegal = w_rtype && !w_f7_base; end
          3'b100: begin w_op = c_OP_XOR;  w_illegal = w_rtype && !w_f7_base; end
          3'b010: begin w_op = c_OP_SLT;  w_illegal = w_rtype && !w_f7_base; end
          3'b011: begin w_op = c_OP_SLTU; w_illegal = w_rtype && !w_f7_base; end
          3'b001: begin w_op = c_OP_SLL;  w_illegal = !w_f7_base; end
          3'b101: begin
            w_op      = w_f7_alt ? c_OP_SRA : c_OP_SRL;
            w_illegal = !(w_f7_base || w_f7_alt);
          end
          default: w_op = c_OP_ADD;
        endcase
      end
    endcase
    if (w_illegal) w_op = c_OP_AND;
  end

  always_comb begin
    w_res = '0;
    if (!w_illegal) begin
      case (w_op)
        c_OP_ADD:  w_res = op_a + op_b;
        c_OP_SUB:  w_res = op_a - op_b;
        c_OP_AND:  w_res = op_a & op_b;
        c_OP_OR:   w_res = op_a | op_b;
        c_OP_XOR:  w_res = op_a ^ op_b;
        c_OP_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        c_OP_SLTU: w_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
        c_OP_SLL:  w_res = op_a << w_shamt;
        c_OP_SRL:  w_res = op_a >> w_shamt;
        c_OP_SRA:  w_res = $unsigned($signed(op_a) >>> w_shamt);
        default:   w_res = '0;
      endcase
    end
  end

  assign in_ready  = !flush && ((r_state == c_ST_IDLE) || ((r_state == c_ST_HOLD) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == c_ST_HOLD);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
  assign operation = r_operation;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_IDLE;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_operation <= 4'b0000;
`ifdef ALU_EXEC_MUL_EN
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
`endif
    end else if (flush) begin
      r_state <= c_ST_IDLE;
`ifdef ALU_EXEC_MUL_EN
      r_cnt   <= '0;
`endif
`ifdef ALU_EXEC_MUL_EN
    end else if (r_state == c_ST_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == c_CNT_LAST) begin
        r_state     <= c_ST_HOLD;
        r_cnt       <= '0;
        r_result    <= w_acc_next;
        r_zero      <= (w_acc_next == '0);
        r_illegal   <= 1'b0;
        r_operation <= c_OP_MUL;
      end
    end else if (w_accept && w_is_mul) begin
      r_state  <= c_ST_MUL;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= op_a;
      r_mplier <= op_b;
`endif
    end else if (w_accept) begin
      r_state     <= c_ST_HOLD;
      r_result    <= w_res;
      r_zero      <= (w_res == '0);
      r_illegal   <= w_illegal;
      r_operation <= w_op;
    end else if ((r_state == c_ST_HOLD) && out_ready) begin
      r_state <= c_ST_IDLE;
    end
  end

endmodule
`default_nettype wire
